// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, 32-bit ALU with NZCV, condition unit owning the
// architectural flags, and the execute-to-memory pipeline register.
module execute_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         PCSrcE,
   input  logic         BranchE,
   input  logic         RegWriteE,
   input  logic         MemWriteE,
   input  logic         MemtoRegE,
   input  logic [3:0]   AluControlE,
   input  logic         AluSrcE,
   input  logic [1:0]   FlagWriteE,
   input  logic [3:0]   CondE,
   input  logic [W-1:0] ExtendImmE,
   input  logic [W-1:0] RD1E,
   input  logic [W-1:0] RD2E,
   input  logic [3:0]   WA3E,
   input  logic [1:0]   ForwardAE,
   input  logic [1:0]   ForwardBE,
   input  logic [W-1:0] ResultW,
   output logic         BranchTakenE,
   output logic [W-1:0] ALUResultE,
   output logic [3:0]   FlagsQ,
   output logic         PCSrcM,
   output logic         RegWriteM,
   output logic         MemWriteM,
   output logic         MemtoRegM,
   output logic [W-1:0] ALUResultM,
   output logic [W-1:0] WriteDataM,
   output logic [3:0]   WA3M
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_MVN = 4'b1111;

   logic [W-1:0] src_a_s;
   logic [W-1:0] fwd_b_s;
   logic [W-1:0] src_b_s;
   logic [W-1:0] alu_res_s;
   logic         alu_c_s;
   logic         alu_v_s;
   logic [W:0]   add_s;
   logic [W:0]   sub_ab_s;
   logic [W:0]   sub_ba_s;
   logic         cond_ex_s;
   logic [3:0]   flags_next_s;

   logic [3:0]   flags_r;
   logic         pcsrc_m_r;
   logic         regwrite_m_r;
   logic         memwrite_m_r;
   logic         memtoreg_m_r;
   logic [W-1:0] alu_result_m_r;
   logic [W-1:0] write_data_m_r;
   logic [3:0]   wa3_m_r;

   // Condition check against flags {N,Z,C,V}; 1111 never executes.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      logic pass;
      {n, z, c, v} = f;
      case (cond)
         4'b0000: pass = z;
         4'b0001: pass = ~z;
         4'b0010: pass = c;
         4'b0011: pass = ~c;
         4'b0100: pass = n;
         4'b0101: pass = ~n;
         4'b0110: pass = v;
         4'b0111: pass = ~v;
         4'b1000: pass = c & ~z;
         4'b1001: pass = ~c | z;
         4'b1010: pass = (n == v);
         4'b1011: pass = (n != v);
         4'b1100: pass = ~z & (n == v);
         4'b1101: pass = z | (n != v);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

   // Operand A forwarding; code 11 is reserved and reads the register value.
   always_comb begin
      case (ForwardAE)
         2'b01:   src_a_s = ResultW;
         2'b10:   src_a_s = alu_result_m_r;
         default: src_a_s = RD1E;
      endcase
   end

   // Operand B forwarding, identical to A.
   always_comb begin
      case (ForwardBE)
         2'b01:   fwd_b_s = ResultW;
         2'b10:   fwd_b_s = alu_result_m_r;
         default: fwd_b_s = RD2E;
      endcase
   end

   assign src_b_s  = AluSrcE ? ExtendImmE : fwd_b_s;

   // Subtraction as A + ~B + 1 so the top carry is directly NOT borrow.
   assign add_s    = {1'b0, src_a_s} + {1'b0, src_b_s};
   assign sub_ab_s = {1'b0, src_a_s} + {1'b0, ~src_b_s} + {{W{1'b0}}, 1'b1};
   assign sub_ba_s = {1'b0, src_b_s} + {1'b0, ~src_a_s} + {{W{1'b0}}, 1'b1};

   // ALU result plus carry/overflow; logical and unknown ops leave C,V at 0.
   always_comb begin
      alu_res_s = {W{1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      case (AluControlE)
         OP_AND: alu_res_s = src_a_s & src_b_s;
         OP_EOR: alu_res_s = src_a_s ^ src_b_s;
         OP_SUB, OP_CMP: begin
            alu_res_s = sub_ab_s[W-1:0];
            alu_c_s   = sub_ab_s[W];
            alu_v_s   = (src_a_s[W-1] != src_b_s[W-1]) & (sub_ab_s[W-1] != src_a_s[W-1]);
         end
         OP_RSB: begin
            alu_res_s = sub_ba_s[W-1:0];
            alu_c_s   = sub_ba_s[W];
            alu_v_s   = (src_a_s[W-1] != src_b_s[W-1]) & (sub_ba_s[W-1] != src_b_s[W-1]);
         end
         OP_ADD: begin
            alu_res_s = add_s[W-1:0];
            alu_c_s   = add_s[W];
            alu_v_s   = (src_a_s[W-1] == src_b_s[W-1]) & (add_s[W-1] != src_a_s[W-1]);
         end
         OP_ORR: alu_res_s = src_a_s | src_b_s;
         OP_MOV: alu_res_s = src_b_s;
         OP_BIC: alu_res_s = src_a_s & ~src_b_s;
         OP_MVN: alu_res_s = ~src_b_s;
         default: alu_res_s = {W{1'b0}};
      endcase
   end

   assign cond_ex_s    = cond_pass(CondE, flags_r);
   assign BranchTakenE = BranchE & cond_ex_s;
   assign ALUResultE   = alu_res_s;

   // Next flags: N,Z and C,V groups update independently when the instruction executes.
   always_comb begin
      flags_next_s = flags_r;
      if (cond_ex_s && FlagWriteE[1]) begin
         flags_next_s[3:2] = {alu_res_s[W-1], (alu_res_s == {W{1'b0}})};
      end else begin
         flags_next_s[3:2] = flags_r[3:2];
      end
      if (cond_ex_s && FlagWriteE[0]) begin
         flags_next_s[1:0] = {alu_c_s, alu_v_s};
      end else begin
         flags_next_s[1:0] = flags_r[1:0];
      end
   end

   // Flags register and execute-to-memory pipeline register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_r        <= 4'b0000;
         pcsrc_m_r      <= 1'b0;
         regwrite_m_r   <= 1'b0;
         memwrite_m_r   <= 1'b0;
         memtoreg_m_r   <= 1'b0;
         alu_result_m_r <= {W{1'b0}};
         write_data_m_r <= {W{1'b0}};
         wa3_m_r        <= 4'b0000;
      end else begin
         flags_r        <= flags_next_s;
         pcsrc_m_r      <= PCSrcE & cond_ex_s;
         regwrite_m_r   <= RegWriteE & cond_ex_s;
         memwrite_m_r   <= MemWriteE & cond_ex_s;
         memtoreg_m_r   <= MemtoRegE;
         alu_result_m_r <= alu_res_s;
         write_data_m_r <= fwd_b_s;
         wa3_m_r        <= WA3E;
      end
   end

   assign FlagsQ     = flags_r;
   assign PCSrcM     = pcsrc_m_r;
   assign RegWriteM  = regwrite_m_r;
   assign MemWriteM  = memwrite_m_r;
   assign MemtoRegM  = memtoreg_m_r;
   assign ALUResultM = alu_result_m_r;
   assign WriteDataM = write_data_m_r;
   assign WA3M       = wa3_m_r;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: constant vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        PCSrcE, BranchE, RegWriteE, MemWriteE, MemtoRegE;
   logic [3:0]  AluControlE;
   logic        AluSrcE;
   logic [1:0]  FlagWriteE;
   logic [3:0]  CondE;
   logic [31:0] ExtendImmE, RD1E, RD2E;
   logic [3:0]  WA3E;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ResultW;
   logic        BranchTakenE;
   logic [31:0] ALUResultE;
   logic [3:0]  FlagsQ;
   logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [3:0]  WA3M;

   execute_stage #(.W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .PCSrcE(PCSrcE), .BranchE(BranchE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .MemtoRegE(MemtoRegE), .AluControlE(AluControlE), .AluSrcE(AluSrcE),
      .FlagWriteE(FlagWriteE), .CondE(CondE), .ExtendImmE(ExtendImmE), .RD1E(RD1E),
      .RD2E(RD2E), .WA3E(WA3E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
      .FlagsQ(FlagsQ), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .MemtoRegM(MemtoRegM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pcsrc, branch, regwrite, memwrite, memtoreg;
      logic [3:0]  op;
      logic        alusrc;
      logic [1:0]  fwe;
      logic [3:0]  cond;
      logic [31:0] imm, rd1, rd2;
      logic [3:0]  wa3;
      logic [1:0]  fa, fb;
      logic [31:0] resw;
   } vin_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [31:0] exp_res;
      logic [3:0]  exp_flags;
   } tv_t;

   typedef struct {
      logic [31:0] res;
      logic        n, z, c, v;
   } alu_t;

   int n_checks = 0;
   int n_errors = 0;

   // reference state
   logic [3:0]  m_flags;
   logic [31:0] m_alu_m, m_wd;
   logic [3:0]  m_wa3;
   logic        m_pcsrc, m_rw, m_mw, m_mtr;
   logic [31:0] last_alu_e;
   logic        last_bt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic alu_t model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_t r;
      longint unsigned ua, ub;
      longint sa, sb, s;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b); s = 0;
      r.c = 1'b0; r.v = 1'b0;
      case (op)
         4'h0: r.res = a & b;
         4'h1: r.res = a ^ b;
         4'h2, 4'hA: begin r.res = a - b; r.c = (ua >= ub); s = sa - sb; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h3: begin r.res = b - a; r.c = (ub >= ua); s = sb - sa; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h4: begin r.res = a + b; r.c = ((ua + ub) > 64'hFFFF_FFFF); s = sa + sb; r.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'hC: r.res = a | b;
         4'hD: r.res = b;
         4'hE: r.res = a & ~b;
         4'hF: r.res = ~b;
         default: r.res = 32'h0;
      endcase
      r.n = r.res[31];
      r.z = (r.res == 32'h0);
      return r;
   endfunction

   function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                             input logic [31:0] w_v, input logic [31:0] m_v);
      if (sel == 2'b01) return w_v;
      else if (sel == 2'b10) return m_v;
      else return reg_v;
   endfunction

   function automatic vin_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      vin_t v;
      v.pcsrc = 1'b0; v.branch = 1'b0; v.regwrite = 1'b0; v.memwrite = 1'b0; v.memtoreg = 1'b0;
      v.op = op; v.alusrc = 1'b0; v.fwe = 2'b11; v.cond = 4'hE;
      v.imm = 32'h0; v.rd1 = a; v.rd2 = b; v.wa3 = 4'h1;
      v.fa = 2'b00; v.fb = 2'b00; v.resw = 32'h0;
      return v;
   endfunction

   task automatic drive(input vin_t v);
      PCSrcE = v.pcsrc; BranchE = v.branch; RegWriteE = v.regwrite; MemWriteE = v.memwrite;
      MemtoRegE = v.memtoreg; AluControlE = v.op; AluSrcE = v.alusrc; FlagWriteE = v.fwe;
      CondE = v.cond; ExtendImmE = v.imm; RD1E = v.rd1; RD2E = v.rd2; WA3E = v.wa3;
      ForwardAE = v.fa; ForwardBE = v.fb; ResultW = v.resw;
   endtask

   task automatic clear_model();
      m_flags = 4'h0; m_alu_m = 32'h0; m_wd = 32'h0; m_wa3 = 4'h0;
      m_pcsrc = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_mtr = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".FlagsQ"}, 32'(FlagsQ), 32'(m_flags));
      check({tag, ".ALUResultM"}, ALUResultM, m_alu_m);
      check({tag, ".WriteDataM"}, WriteDataM, m_wd);
      check({tag, ".WA3M"}, 32'(WA3M), 32'(m_wa3));
      check({tag, ".ctrlM"}, 32'({PCSrcM, RegWriteM, MemWriteM, MemtoRegM}),
            32'({m_pcsrc, m_rw, m_mw, m_mtr}));
   endtask

   // One instruction: drive, check combinational outputs, clock, check registered outputs.
   task automatic cycle(input vin_t v, input string tag);
      logic [31:0] a, fb, b;
      alu_t        r;
      logic        ok;
      drive(v);
      #1;
      a  = model_fwd(v.fa, v.rd1, v.resw, m_alu_m);
      fb = model_fwd(v.fb, v.rd2, v.resw, m_alu_m);
      b  = v.alusrc ? v.imm : fb;
      r  = model_alu(v.op, a, b);
      ok = model_cond(v.cond, m_flags);
      last_alu_e = ALUResultE;
      last_bt    = BranchTakenE;
      check({tag, ".ALUResultE"}, ALUResultE, r.res);
      check({tag, ".BranchTakenE"}, 32'(BranchTakenE), 32'(v.branch & ok));
      if (ok && v.fwe[1]) begin m_flags[3] = r.n; m_flags[2] = r.z; end
      if (ok && v.fwe[0]) begin m_flags[1] = r.c; m_flags[0] = r.v; end
      m_alu_m = r.res; m_wd = fb; m_wa3 = v.wa3;
      m_pcsrc = v.pcsrc & ok; m_rw = v.regwrite & ok; m_mw = v.memwrite & ok; m_mtr = v.memtoreg;
      @(posedge clk);
      #1;
      check_regs(tag);
   endtask

   tv_t  tbl [14];
   vin_t v;

   initial begin
      tbl[0]  = '{4'h4, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      tbl[1]  = '{4'h2, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
      tbl[2]  = '{4'h2, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000};
      tbl[3]  = '{4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      tbl[4]  = '{4'h3, 32'h0000_0003, 32'h0000_0005, 32'h0000_0002, 4'b0010};
      tbl[5]  = '{4'hA, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      tbl[6]  = '{4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
      tbl[7]  = '{4'h1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b1000};
      tbl[8]  = '{4'hC, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
      tbl[9]  = '{4'hD, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 4'b0000};
      tbl[10] = '{4'hE, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 4'b1000};
      tbl[11] = '{4'hF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};
      tbl[12] = '{4'h5, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 4'b0100};
      tbl[13] = '{4'h4, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};

      // Reset asserted from time zero with non-zero inputs.
      reset_n = 1'b0;
      v = mk(4'h4, 32'h1111_1111, 32'h2222_2222);
      v.regwrite = 1'b1; v.memtoreg = 1'b1; v.wa3 = 4'h7;
      drive(v);
      clear_model();
      #2;
      check_regs("reset0");
      @(negedge clk);
      reset_n = 1'b1;
      cycle(v, "first_edge");

      foreach (tbl[i]) begin
         cycle(mk(tbl[i].op, tbl[i].a, tbl[i].b), "table");
         check("table.res", ALUResultM, tbl[i].exp_res);
         check("table.flags", 32'(FlagsQ), 32'(tbl[i].exp_flags));
      end

      // Conditional kill: Z=1, NE fails.
      cycle(mk(4'h2, 32'h5, 32'h5), "setz");
      v = mk(4'h4, 32'h1, 32'h2);
      v.cond = 4'h1; v.regwrite = 1'b1; v.memwrite = 1'b1; v.branch = 1'b1; v.pcsrc = 1'b1;
      cycle(v, "kill");
      check("kill.RegWriteM", 32'(RegWriteM), 32'h0);
      check("kill.MemWriteM", 32'(MemWriteM), 32'h0);
      check("kill.BranchTakenE", 32'(last_bt), 32'h0);
      check("kill.FlagsQ", 32'(FlagsQ), 32'h6);
      v.cond = 4'h0; v.rd1 = 32'h0; v.rd2 = 32'h0;
      cycle(v, "pass");
      check("pass.RegWriteM", 32'(RegWriteM), 32'h1);
      check("pass.MemWriteM", 32'(MemWriteM), 32'h1);
      check("pass.BranchTakenE", 32'(last_bt), 32'h1);

      // Back-to-back: CMP sets Z, BEQ in the very next cycle sees it.
      cycle(mk(4'h4, 32'h1, 32'h1), "clrz");
      cycle(mk(4'hA, 32'h1, 32'h1), "cmp");
      v = mk(4'h4, 32'h100, 32'h4);
      v.cond = 4'h0; v.branch = 1'b1; v.fwe = 2'b00;
      cycle(v, "beq");
      check("beq.taken", 32'(last_bt), 32'h1);
      check("beq.target", last_alu_e, 32'h104);

      // Forwarding paths.
      cycle(mk(4'h4, 32'h10, 32'h0), "fwd_seed");
      v = mk(4'h4, 32'h0, 32'h0);
      v.fa = 2'b10; v.fb = 2'b01; v.resw = 32'h20;
      cycle(v, "fwd_mw");
      check("fwd_mw.ALUResultE", last_alu_e, 32'h30);
      check("fwd_mw.WriteDataM", WriteDataM, 32'h20);
      v = mk(4'h4, 32'h7, 32'h1);
      v.fa = 2'b11; v.resw = 32'h20;
      cycle(v, "fwd_rsv");
      check("fwd_rsv.ALUResultE", last_alu_e, 32'h8);
      v = mk(4'h4, 32'h0, 32'h0);
      v.fa = 2'b10; v.fb = 2'b10;
      cycle(v, "fwd_both");
      check("fwd_both.ALUResultE", last_alu_e, 32'h10);

      // Mid-run asynchronous reset, held across an edge with live inputs.
      v = mk(4'hF, 32'h0, 32'h0);
      v.regwrite = 1'b1; v.pcsrc = 1'b1; v.memwrite = 1'b1; v.memtoreg = 1'b1; v.wa3 = 4'hC;
      cycle(v, "pre_reset");
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      clear_model();
      check_regs("async_reset");
      @(posedge clk);
      #1;
      check_regs("held_reset");
      @(negedge clk);
      reset_n = 1'b1;
      cycle(v, "post_reset");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         v.pcsrc = 1'($urandom); v.branch = 1'($urandom); v.regwrite = 1'($urandom);
         v.memwrite = 1'($urandom); v.memtoreg = 1'($urandom);
         v.op = 4'($urandom); v.alusrc = 1'($urandom); v.fwe = 2'($urandom);
         v.cond = 4'($urandom); v.imm = $urandom;
         v.rd1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
         v.wa3 = 4'($urandom); v.fa = 2'($urandom); v.fb = 2'($urandom); v.resw = $urandom;
         cycle(v, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
